// File: rtl/unified_mem_arbiter.sv
// Purpose : shares one single-ported memory between the instruction-fetch (IF) and data-memory (DM) stages.
// Latency : req sampled in cycle 0 -> mem_req in cycle 1 -> mem_ack in cycle k -> ready pulse in cycle k+1 (3 cycles minimum).
// Backpressure: one transaction at a time; a requester holds req until its ready pulse, and stall_* tell the pipeline to wait.
//
// Optional feature macro: ARB_TIMEOUT_EN (abort a BUSY transaction after TIMEOUT_CYCLES without mem_ack).
//
// Ports:
//   clk, reset (async, active-low)
//   if_req/if_addr            -> if_rdata (32b lane of the 64b word), if_ready pulse
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb -> dm_rdata, dm_ready pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb <- mem_rdata, mem_ack
//   stall_if, stall_mem       combinational stall requests to the hazard unit
//   bus_err                   timeout flag, pulses together with the ready pulse
module unified_mem_arbiter #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int MAX_DM_STREAK  = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic [7:0]        dm_wstrb,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wstrb,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              bus_err
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

   localparam logic [3:0] MAX_STREAK = 4'(MAX_DM_STREAK);

   state_t     state;
   logic [3:0] dm_streak;
   logic       if_sel_hi;   // latched if_addr[2]: which 32-bit half holds the instruction
   logic       err_q;
   logic       grant_dm;
   logic       grant_if;
   logic       timed_out;

   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = dm_req & ~dm_ready;
   assign bus_err   = err_q;

   // DM has priority, except when it has already won MAX_DM_STREAK times in a row
   // while IF was waiting; then IF gets the next slot.
   always_comb begin
      grant_dm = dm_req & (~if_req | (dm_streak != MAX_STREAK));
      grant_if = if_req & ~grant_dm;
   end

`ifdef ARB_TIMEOUT_EN
   localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] to_cnt;

   // Counts BUSY cycles starting at 0 in the first mem_req cycle; reaching
   // TIMEOUT_CYCLES means TIMEOUT_CYCLES full cycles passed with no ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
      end else if (state == IDLE) begin
         to_cnt <= '0;
      end else if ((state == BUSY_IF || state == BUSY_DM) && !mem_ack) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timed_out = (to_cnt == TO_LAST);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timed_out          = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         dm_streak <= '0;
         if_sel_hi <= 1'b0;
         err_q     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_dm) begin
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  mem_wstrb <= dm_wstrb;
                  // streak only grows while IF is actually being held off
                  dm_streak <= if_req ? dm_streak + 4'd1 : 4'd0;
                  state     <= BUSY_DM;
               end else if (grant_if) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  mem_wstrb <= '0;
                  if_sel_hi <= if_addr[2];
                  dm_streak <= 4'd0;
                  state     <= BUSY_IF;
               end
            end
            BUSY_IF: begin
               // ack on the same edge as the timeout is a normal completion
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  if_rdata <= if_sel_hi ? mem_rdata[63:32] : mem_rdata[31:0];
                  if_ready <= 1'b1;
                  state    <= RESP;
               end else if (timed_out) begin
                  mem_req  <= 1'b0;
                  if_rdata <= '0;
                  if_ready <= 1'b1;
                  err_q    <= 1'b1;
                  state    <= RESP;
               end
            end
            BUSY_DM: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  if (!mem_we) begin
                     dm_rdata <= mem_rdata;   // stores leave the last load data in place
                  end
                  dm_ready <= 1'b1;
                  state    <= RESP;
               end else if (timed_out) begin
                  mem_req  <= 1'b0;
                  dm_rdata <= '0;
                  dm_ready <= 1'b1;
                  err_q    <= 1'b1;
                  state    <= RESP;
               end
            end
            RESP: begin
               // ready pulse cycle; no grant here so a held req is not served twice
               if_ready <= 1'b0;
               dm_ready <= 1'b0;
               err_q    <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Purpose : self-checking bench for unified_mem_arbiter with a behavioural memory and response scoreboard.
// Latency : memory acks a configurable number of cycles after mem_req rises.
// Backpressure: requesters hold req until their ready pulse, as the pipeline does.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, dm_req, dm_we;
   logic [63:0] if_addr, dm_addr, dm_wdata, dm_rdata;
   logic [31:0] if_rdata;
   logic [7:0]  dm_wstrb, mem_wstrb;
   logic        if_ready, dm_ready, mem_req, mem_we, mem_ack;
   logic [63:0] mem_addr, mem_wdata;
   logic [63:0] mem_rdata = 64'd0;
   logic        stall_if, stall_mem, bus_err;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   unified_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_DM_STREAK(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
   );

   typedef struct { bit dm; logic [63:0] data; bit err; } rsp_t;
   typedef struct { bit we; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wstrb; } txn_t;

   rsp_t rq[$];
   txn_t mq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   ready_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] rdata_fn(input logic [63:0] a);
      if (a == 64'h104)  return 64'hDEADBEEF_00500093;
      if (a == 64'h2000) return 64'h11;
      return {a[31:0], ~a[31:0]};
   endfunction

   // ---------------- response scoreboard ----------------
   rsp_t mon_r;
   always @(negedge clk) begin
      if (if_ready || dm_ready) begin
         ready_cnt++;
         check("ready_onehot", 64'(if_ready & dm_ready), 64'd0);
         check("rsp_expected", 64'(rq.size() != 0), 64'd1);
         if (rq.size() != 0) begin
            mon_r = rq.pop_front();
            check("rsp_port", 64'(dm_ready), 64'(mon_r.dm));
            if (mon_r.dm) check("dm_rdata", dm_rdata, mon_r.data);
            else          check("if_rdata", {32'd0, if_rdata}, mon_r.data);
            check("bus_err", 64'(bus_err), 64'(mon_r.err));
         end
      end
   end

   // ---------------- memory model ----------------
   bit   model_en = 1'b1;
   bit   manual_ack = 1'b0;
   int   ack_delay = 0;
   int   wcnt = 0;
   bit   acked = 1'b0;
   bit   unstable = 1'b0;
   bit   prev_req = 1'b0;
   int   req_rise_cyc = 0;
   txn_t snap, mod_t;

   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (mem_req && !prev_req) begin
         req_rise_cyc = cyc;
         snap     = '{mem_we, mem_addr, mem_wdata, mem_wstrb};
         unstable = 1'b0;
         wcnt     = 0;
         acked    = 1'b0;
      end
      prev_req = mem_req;
      if (mem_req && (snap.we !== mem_we || snap.addr !== mem_addr ||
                      snap.wdata !== mem_wdata || snap.wstrb !== mem_wstrb))
         unstable = 1'b1;
      if (manual_ack) begin
         mem_ack = 1'b1;
      end else if (model_en && mem_req && !acked) begin
         if (wcnt >= ack_delay) begin
            mem_ack   = 1'b1;
            acked     = 1'b1;
            mem_rdata = rdata_fn(mem_addr);
            check("mem_stable", 64'(unstable), 64'd0);
            check("txn_expected", 64'(mq.size() != 0), 64'd1);
            if (mq.size() != 0) begin
               mod_t = mq.pop_front();
               check("mem_we", 64'(mem_we), 64'(mod_t.we));
               check("mem_addr", mem_addr, mod_t.addr);
               check("mem_wstrb", 64'(mem_wstrb), 64'(mod_t.wstrb));
               if (mod_t.we) check("mem_wdata", mem_wdata, mod_t.wdata);
            end
         end else begin
            wcnt++;
         end
      end
   end

   // ---------------- requester helpers ----------------
   logic [63:0] dm_hold = 64'd0;

   task automatic expect_if(input logic [63:0] a, input logic [31:0] d);
      rq.push_back('{1'b0, {32'd0, d}, 1'b0});
      mq.push_back('{1'b0, a, 64'd0, 8'd0});
   endtask

   task automatic expect_dm(input bit we, input logic [63:0] a, input logic [63:0] wd,
                            input logic [7:0] ws, input logic [63:0] d);
      if (!we) dm_hold = d;
      rq.push_back('{1'b1, dm_hold, 1'b0});
      mq.push_back('{we, a, wd, ws});
   endtask

   task automatic wait_rdy(input bit dm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(dm ? dm_ready : if_ready) && n < 300);
      check(dm ? "dm_ready_seen" : "if_ready_seen", 64'(dm ? dm_ready : if_ready), 64'd1);
   endtask

   task automatic do_fetch(input logic [63:0] a);
      if_addr = a;
      if_req  = 1'b1;
      wait_rdy(1'b0);
      if_req  = 1'b0;
   endtask

   task automatic do_dm(input bit we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] ws);
      dm_we = we; dm_addr = a; dm_wdata = wd; dm_wstrb = ws;
      dm_req = 1'b1;
      wait_rdy(1'b1);
      dm_req = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctl"}, 64'({mem_req, mem_we, mem_wstrb, if_ready, dm_ready, bus_err, stall_if, stall_mem}), 64'd0);
      check({name, "_mem_addr"}, mem_addr, 64'd0);
      check({name, "_mem_wdata"}, mem_wdata, 64'd0);
      check({name, "_rdata"}, {32'd0, if_rdata} | dm_rdata, 64'd0);
   endtask

   typedef struct {
      bit          use_if, use_dm, we;
      logic [63:0] ia, da, wd;
      logic [7:0]  ws;
      int          dly;
      logic [31:0] exp_if;
      logic [63:0] exp_dm;
   } vec_t;

   vec_t vt[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          c0;
      bit          st;
      logic [63:0] a;

      vt[0] = '{1, 0, 0, 64'h104,  64'h0,    64'h0,                 8'h00, 1, 32'hDEADBEEF, 64'h0};
      vt[1] = '{1, 1, 0, 64'h100,  64'h2000, 64'h0,                 8'h00, 0, 32'hFFFFFEFF, 64'h11};
      vt[2] = '{0, 1, 0, 64'h0,    64'h4000, 64'h0,                 8'h00, 2, 32'h0,        64'h00004000_FFFFBFFF};
      vt[3] = '{0, 1, 1, 64'h0,    64'h3008, 64'hA5A5,              8'h0F, 5, 32'h0,        64'h00004000_FFFFBFFF};
      vt[4] = '{1, 0, 0, 64'h10C,  64'h0,    64'h0,                 8'h00, 3, 32'h0000010C, 64'h0};
      vt[5] = '{1, 1, 1, 64'h2004, 64'h5000, 64'h11223344_55667788, 8'hFF, 1, 32'h00002004, 64'h00004000_FFFFBFFF};

      reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // single fetch with cycle-accurate latency and stall checks
      ack_delay = 1;
      expect_if(64'h104, 32'hDEADBEEF);
      c0 = cyc;
      if_addr = 64'h104; if_req = 1'b1;
      #1 st = stall_if;
      @(negedge clk); st &= stall_if;
      check("fetch_memreq_c1", 64'(mem_req), 64'd1);
      @(negedge clk); st &= stall_if;
      @(negedge clk);
      check("fetch_ready_c3", 64'(if_ready), 64'd1);
      check("fetch_cycle", 64'(cyc - c0), 64'd3);
      check("stall_if_c0_2", 64'(st), 64'd1);
      check("stall_if_c3", 64'(stall_if), 64'd0);
      if (!if_ready) wait_rdy(1'b0);
      if_req = 1'b0;
      @(negedge clk);
      check("if_ready_pulse", 64'(if_ready), 64'd0);

      // table-driven vectors; simultaneous requests are served DM first
      for (int i = 0; i < 6; i++) begin
         ack_delay = vt[i].dly;
         if (vt[i].use_dm) expect_dm(vt[i].we, vt[i].da, vt[i].wd, vt[i].ws, vt[i].exp_dm);
         if (vt[i].use_if) expect_if(vt[i].ia, vt[i].exp_if);
         fork
            begin if (vt[i].use_dm) do_dm(vt[i].we, vt[i].da, vt[i].wd, vt[i].ws); end
            begin if (vt[i].use_if) do_fetch(vt[i].ia); end
         join
         @(negedge clk);
      end

      // starvation: DM held continuously; IF issues two fetches back to back.
      // Expected order DM x4, IF, DM, DM, IF (streak restarts after the IF grant).
      ack_delay = 0;
      for (int k = 0; k < 4; k++) begin
         a = 64'h6000 + 64'(8 * k);
         expect_dm(1'b0, a, 64'd0, 8'd0, rdata_fn(a));
      end
      expect_if(64'h300, 32'hFFFFFCFF);
      for (int k = 4; k < 6; k++) begin
         a = 64'h6000 + 64'(8 * k);
         expect_dm(1'b0, a, 64'd0, 8'd0, rdata_fn(a));
      end
      expect_if(64'h308, 32'hFFFFFCF7);
      fork
         begin
            dm_we = 1'b0; dm_wstrb = 8'd0; dm_wdata = 64'd0; dm_req = 1'b1;
            for (int k = 0; k < 6; k++) begin
               dm_addr = 64'h6000 + 64'(8 * k);
               wait_rdy(1'b1);
            end
            dm_req = 1'b0;
         end
         begin
            do_fetch(64'h300);
            do_fetch(64'h308);
         end
      join
      @(negedge clk);

      // reset during BUSY_DM, then a late ack must not produce a ready pulse
      model_en = 1'b0;
      dm_we = 1'b0; dm_addr = 64'h7000; dm_req = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pre_memreq", 64'(mem_req), 64'd1);
      reset = 1'b0; dm_req = 1'b0;
      #1 check_all_zero("rst_mid");
      @(negedge clk);
      reset = 1'b1;
      c0 = ready_cnt;
      @(negedge clk);
      manual_ack = 1'b1;
      @(negedge clk);
      manual_ack = 1'b0;
      repeat (5) @(negedge clk);
      check("late_ack_no_ready", 64'(ready_cnt - c0), 64'd0);
      check("late_ack_memreq", 64'(mem_req), 64'd0);
      model_en = 1'b1;

      // normal load after reset recovery
      ack_delay = 2;
      expect_dm(1'b0, 64'h2000, 64'd0, 8'd0, 64'h11);
      do_dm(1'b0, 64'h2000, 64'd0, 8'd0);
      @(negedge clk);

`ifdef ARB_TIMEOUT_EN
      // no ack: ready and bus_err together 17 cycles after mem_req rises
      model_en = 1'b0;
      rq.push_back('{1'b1, 64'd0, 1'b1});
      do_dm(1'b0, 64'h8000, 64'd0, 8'd0);
      check("timeout_latency", 64'(cyc - req_rise_cyc), 64'd17);
      model_en = 1'b1;
      @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      check("rsp_drained", 64'(rq.size()), 64'd0);
      check("txn_drained", 64'(mq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the RISC_V_Processor instruction-fetch (IF) stage and data-memory (MEM) stage.
- Arbitrates between the two requesters and sequences each memory transaction through a request/acknowledge handshake.
- Returns read data to the granted requester and drives per-stage stall signals into the pipeline hazard logic.
- Sits between the pipeline core and the memory model/controller, with one outstanding transaction at a time.

Parameters:
- ADDR_W, 64, address width of both requesters and the memory port.
- DATA_W, 64, memory data width; fixed at 64.
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF is waiting before IF is forced; legal range 1..15.
- TIMEOUT_CYCLES, 16, cycles to wait for mem_ack before abort; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  ADDR_W  fetch byte address, 4-byte aligned.
- if_rdata  out  32  instruction word.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held high until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  64  store data.
- dm_wstrb  in  8  store byte enables.
- dm_rdata  out  64  load data.
- dm_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory transaction valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  64  memory write data.
- mem_wstrb  out  8  memory byte enables.
- mem_rdata  in  64  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, single-cycle.
- stall_if  out  1  combinational: if_req & ~if_ready.
- stall_mem  out  1  combinational: dm_req & ~dm_ready.
- bus_err  out  1  timeout error pulse, coincident with a ready pulse.

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- Reset values: state = IDLE; all outputs 0 (mem_addr, mem_wdata, if_rdata, dm_rdata = 0); dm_streak = 0.
- IDLE, only one requester active: grant it.
- IDLE, both active:
  - grant DM, unless dm_streak == MAX_DM_STREAK, in which case grant IF.
  - a DM grant while if_req is high increments dm_streak.
  - any IF grant clears dm_streak.
  - a DM grant with if_req low clears dm_streak.
- On grant: register address, we, wdata and wstrb onto the mem_* outputs, set mem_req = 1, and go to BUSY_IF or BUSY_DM.
  - An IF grant drives mem_we = 0 and mem_wstrb = 0.
- BUSY_x:
  - mem_* outputs stay stable until mem_ack is sampled high.
  - On mem_ack: mem_req drops to 0 and the state moves to RESP.
  - Read data is captured into if_rdata or dm_rdata.
  - if_rdata = mem_rdata[63:32] when the latched if_addr[2] = 1, else mem_rdata[31:0].
- RESP: assert the granted ready for exactly one cycle, then go to IDLE. No new grant is issued in RESP, so a requester still holding req in that cycle is not regranted.
- Latency: req high in cycle 0 → mem_req high in cycle 1 → ack in cycle k (k ≥ 1) → ready in cycle k+1. Minimum 3 cycles per transaction.
- Read-data hold: dm_rdata and if_rdata keep their value until the next capture. Stores leave dm_rdata unchanged.
- mem_ack in IDLE or RESP: ignored.
- Requester drops req while BUSY: the transaction completes; the ready pulse is still issued.
- reset asserted mid-transaction: immediate return to IDLE with mem_req = 0. The abandoned transaction's ack is ignored.
- Address alignment is not checked.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in BUSY_x.
  - If no mem_ack arrives within TIMEOUT_CYCLES cycles after mem_req rises, the transaction aborts: mem_req → 0, state → RESP.
  - The ready pulse is issued with bus_err = 1 in the same cycle, and the rdata output is set to 0.
  - An ack arriving on the same edge as the timeout wins (normal completion).
- Undefined: no counter; BUSY_x waits indefinitely; bus_err is tied to 0.

Test Plan:
- Single fetch: if_addr = 0x104, mem_ack 1 cycle after mem_req with mem_rdata = 0xDEADBEEF_00500093 → if_rdata = 0xDEADBEEF, if_ready at cycle 3, stall_if high in cycles 0-2.
- Simultaneous if_req and dm_req (load 0x2000, mem_rdata = 0x11) → DM served first (dm_rdata = 0x11), IF served next, no overlap of mem_req.
- Starvation: dm_req held continuously, if_req high, MAX_DM_STREAK = 4 → exactly 4 DM grants, then 1 IF grant, dm_streak = 0 afterwards.
- Store: dm_we = 1, addr 0x3008, wdata 0xA5A5, wstrb 0x0F → mem_we = 1 and mem_* stable through a 5-cycle ack delay; dm_ready one cycle after ack; dm_rdata unchanged.
- Reset pulled low while BUSY_DM → all outputs 0 immediately; a late mem_ack after release produces no ready pulse.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, no ack → dm_ready and bus_err pulse together 17 cycles after mem_req rises, dm_rdata = 0.
